hja_led_scan: RTL

HJA_LED_SCAN -- requirements
Module: hja_led_scan

---
 rtl/hja_led_scan_if.sv | 21 ++
 rtl/hja_led_scan.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/hja_led_scan_if.sv
// rtl/hja_led_scan_if.sv - board switch/button inputs, debug mux data and LED outputs of the scanner
interface hja_led_scan_if;
  logic [15:0] sw;
  logic        step;
  logic        trig;
  logic [15:0] led_in;
  logic [7:0]  page_sel;
  logic [15:0] led_out;
  logic        scanning;
  logic        frozen;

  modport master (
    output sw, step, trig, led_in,
    input  page_sel, led_out, scanning, frozen
  );

  modport slave (
    input  sw, step, trig, led_in,
    output page_sel, led_out, scanning, frozen
  );
endinterface

// File: rtl/hja_led_scan.sv
// rtl/hja_led_scan.sv - LED debug page scanner: manual / timed scan / single step / trigger capture
// Optional capture (armed/frozen snapshot) enabled by defining HJA_LED_SCAN_CAPTURE_EN.
module hja_led_scan #(
  parameter logic [31:0] DWELL    = 32'd25_000_000,
  parameter logic [7:0]  PAGE_MAX = 8'h44
) (
  input logic           clk,
  input logic           rst,
  hja_led_scan_if.slave bus
);

  typedef enum logic [2:0] {
    S_MANUAL = 3'd0,
    S_SCAN   = 3'd1,
    S_STEP   = 3'd2,
    S_ARMED  = 3'd3,
    S_FROZEN = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [7:0]  page_q, page_d;
  logic [31:0] dwell_q, dwell_d;
  logic [15:5] sw_q;
  logic        step_q, step_p;
  logic [7:0]  page_sel_d;
  logic [15:0] led_out_d;
  logic        scanning_d, frozen_d;
  logic [7:0]  page_adv, start_page;
  state_t      mode_state;

`ifdef HJA_LED_SCAN_CAPTURE_EN
  logic        trig_q, trig_p;
  logic [15:0] snap_q, snap_d;
`endif

  assign page_adv   = (page_q == PAGE_MAX) ? 8'h00 : page_q + 8'd1;
  assign start_page = (sw_q[15:8] > PAGE_MAX) ? 8'h00 : sw_q[15:8];

  always_comb begin
    case (sw_q[7:6])
      2'b01:   mode_state = S_SCAN;
      2'b10:   mode_state = S_STEP;
`ifdef HJA_LED_SCAN_CAPTURE_EN
      2'b11:   mode_state = S_ARMED;
`endif
      default: mode_state = S_MANUAL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_MANUAL;
      mode_q       <= 2'b00;
      page_q       <= 8'h00;
      dwell_q      <= 32'd0;
      sw_q         <= '0;
      step_q       <= 1'b0;
      step_p       <= 1'b0;
      bus.page_sel <= 8'h00;
      bus.led_out  <= 16'h0000;
      bus.scanning <= 1'b0;
      bus.frozen   <= 1'b0;
`ifdef HJA_LED_SCAN_CAPTURE_EN
      trig_q       <= 1'b0;
      trig_p       <= 1'b0;
      snap_q       <= 16'h0000;
`endif
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      page_q       <= page_d;
      dwell_q      <= dwell_d;
      sw_q         <= bus.sw[15:5];
      step_q       <= bus.step;
      step_p       <= step_q;
      bus.page_sel <= page_sel_d;
      bus.led_out  <= led_out_d;
      bus.scanning <= scanning_d;
      bus.frozen   <= frozen_d;
`ifdef HJA_LED_SCAN_CAPTURE_EN
      trig_q       <= bus.trig;
      trig_p       <= trig_q;
      snap_q       <= snap_d;
`endif
    end
  end

  // A mode-field change always wins over the per-state activity of this cycle.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    page_d  = page_q;
    dwell_d = dwell_q;
`ifdef HJA_LED_SCAN_CAPTURE_EN
    snap_d  = snap_q;
`endif
    if (sw_q[7:6] != mode_q) begin
      mode_d  = sw_q[7:6];
      state_d = mode_state;
      page_d  = start_page;
      dwell_d = 32'd0;
    end else begin
      case (state_q)
        S_SCAN: begin
          if (dwell_q == DWELL - 32'd1) begin
            dwell_d = 32'd0;
            page_d  = page_adv;
          end else begin
            dwell_d = dwell_q + 32'd1;
          end
        end
        S_STEP: begin
          dwell_d = 32'd0;
          if (step_q && !step_p) page_d = page_adv;
        end
`ifdef HJA_LED_SCAN_CAPTURE_EN
        S_ARMED: begin
          if (trig_q && !trig_p) begin
            snap_d  = bus.led_in;
            state_d = S_FROZEN;
          end
        end
        S_FROZEN: begin
          // Release beats a simultaneous trigger edge; snap is not touched here.
          if (sw_q[5]) state_d = S_ARMED;
        end
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    scanning_d = (state_d == S_SCAN);
    frozen_d   = 1'b0;
    page_sel_d = sw_q[15:8];
    led_out_d  = bus.led_in;
    if (state_d == S_SCAN || state_d == S_STEP) page_sel_d = page_d;
`ifdef HJA_LED_SCAN_CAPTURE_EN
    if (state_d == S_FROZEN) begin
      frozen_d  = 1'b1;
      led_out_d = snap_d;
    end
`endif
  end

endmodule
